// File: rtl/mux_nway_reg_pkg.sv
// Shared constants and helpers for the N-way registered mux: selection modes,
// transfer counter width and small index utilities.
package mux_nway_reg_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;
    localparam int XFER_CNT_W   = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Wraps an index that can exceed n by at most n back into 0..n-1.
    function automatic int wrap_idx(input int value, input int n);
        return (value >= n) ? value - n : value;
    endfunction

endpackage

// File: rtl/mux_nway_rr_arb.sv
// Combinational round-robin pick: first valid channel at or above rr_ptr,
// wrapping from CHANNELS-1 back to 0.
module mux_nway_rr_arb
    import mux_nway_reg_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [SEL_W-1:0]    rr_ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_valid && (i == wrap_idx(int'(rr_ptr) + k, CHANNELS)) && in_valid[i]) begin
                    grant       = SEL_W'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_nway_reg.sv
// N-channel registered mux with valid/ready on every port, explicit-select or
// round-robin grant, transfer counter and sticky bad-select flag.
// Optional MUX_NWAY_XMERGE_EN: unknown select merges all matching channels.
module mux_nway_reg
    import mux_nway_reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic [XFER_CNT_W-1:0]     xfer_cnt,
    output logic                      sel_err
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

    // Handshake: a word moves on an edge where valid && ready are both high;
    // ready is offered only to the granted channel and only when the output
    // slot is empty or draining this cycle.
    logic                slot_free;
    logic                sel_known;
    logic                sel_in_range;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    rr_grant;
    logic                rr_grant_valid;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                sel_err_set;
    logic                g_valid;
    logic [WIDTH-1:0]    g_data;
    logic [CHANNELS-1:0] grant_ready;
    logic                load;
    logic [CHANNELS-1:0] ready_f;
    logic                load_f;
    logic [WIDTH-1:0]    load_data;
    logic [SEL_W-1:0]    load_chan;

    assign slot_free    = !out_valid || out_ready;
    assign sel_known    = !$isunknown(sel);
    assign sel_in_range = ({1'b0, sel} < CH_LIMIT);

    mux_nway_rr_arb #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr_arb (
        .in_valid    (in_valid),
        .rr_ptr      (rr_ptr),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    always_comb begin
        grant_idx   = '0;
        grant_vld   = 1'b0;
        sel_err_set = 1'b0;
        if (MODE == MUX_MODE_RR) begin
            grant_idx = rr_grant;
            grant_vld = rr_grant_valid;
        end else if (sel_known && sel_in_range) begin
            grant_idx = sel;
            grant_vld = 1'b1;
        end else begin
`ifdef MUX_NWAY_XMERGE_EN
            sel_err_set = sel_known;
`else
            sel_err_set = 1'b1;
`endif
        end
    end

    // Equality scan keeps every index in range even when SEL_W is wide.
    always_comb begin
        g_valid     = 1'b0;
        g_data      = '0;
        grant_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_vld && (grant_idx == SEL_W'(i))) begin
                g_valid        = in_valid[i];
                g_data         = in_data[i*WIDTH +: WIDTH];
                grant_ready[i] = slot_free;
            end
        end
    end

    assign load = grant_vld && slot_free && g_valid;

`ifdef MUX_NWAY_XMERGE_EN
    logic [CHANNELS-1:0] cand;
    logic [WIDTH-1:0]    m_and;
    logic [WIDTH-1:0]    m_or;
    logic [WIDTH-1:0]    xm_data;
    logic                xm_take;

    always_comb begin
        cand  = '0;
        m_and = '1;
        m_or  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand[i] = 1'b1;
            for (int b = 0; b < SEL_W; b++) begin
                if (!$isunknown(sel[b]) && (sel[b] != 1'(i >> b))) cand[i] = 1'b0;
            end
            if (cand[i]) begin
                m_and = m_and & in_data[i*WIDTH +: WIDTH];
                m_or  = m_or  | in_data[i*WIDTH +: WIDTH];
            end
        end
        for (int w = 0; w < WIDTH; w++) begin
            xm_data[w] = m_and[w] ? 1'b1 : (m_or[w] ? 1'bx : 1'b0);
        end
    end

    assign xm_take   = (MODE == MUX_MODE_SEL) && !sel_known && slot_free &&
                       (|cand) && ((cand & in_valid) == cand);
    assign ready_f   = xm_take ? cand : grant_ready;
    assign load_f    = load || xm_take;
    assign load_data = xm_take ? xm_data : g_data;
    assign load_chan = xm_take ? 'x : grant_idx;
`else
    assign ready_f   = grant_ready;
    assign load_f    = load;
    assign load_data = g_data;
    assign load_chan = grant_idx;
`endif

    assign in_ready = rst_n ? ready_f : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            xfer_cnt  <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1'b1;
            if (load_f) begin
                out_data  <= load_data;
                out_chan  <= load_chan;
                out_valid <= 1'b1;
                if (MODE == MUX_MODE_RR)
                    rr_ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (sel_err_set) sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_nway_reg.sv
// Directed bench for mux_nway_reg: explicit select, backpressure, round-robin,
// bad select, asynchronous reset and (4-state simulators) the x-merge row.
module tb_mux_nway_reg;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // explicit select, 4 x 8-bit, SEL_W=2
    logic [3:0]  s_in_valid, s_in_ready;
    logic [31:0] s_in_data;
    logic [1:0]  s_sel, s_out_chan;
    logic        s_out_valid, s_out_ready, s_sel_err;
    logic [7:0]  s_out_data;
    logic [15:0] s_xfer_cnt;

    // round-robin
    logic [3:0]  r_in_valid, r_in_ready;
    logic [31:0] r_in_data;
    logic [1:0]  r_sel, r_out_chan;
    logic        r_out_valid, r_out_ready, r_sel_err;
    logic [7:0]  r_out_data;
    logic [15:0] r_xfer_cnt;

    // explicit select with SEL_W=4
    logic [3:0]  w_in_valid, w_in_ready;
    logic [31:0] w_in_data;
    logic [3:0]  w_sel, w_out_chan;
    logic        w_out_valid, w_out_ready, w_sel_err;
    logic [7:0]  w_out_data;
    logic [15:0] w_xfer_cnt;

    mux_nway_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .sel(s_sel), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_chan(s_out_chan), .xfer_cnt(s_xfer_cnt), .sel_err(s_sel_err)
    );

    mux_nway_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .in_data(r_in_data), .sel(r_sel), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .out_data(r_out_data), .out_chan(r_out_chan), .xfer_cnt(r_xfer_cnt), .sel_err(r_sel_err)
    );

    mux_nway_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(4), .MODE(0)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .sel(w_sel), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_chan(w_out_chan), .xfer_cnt(w_xfer_cnt), .sel_err(w_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", s_out_valid); end
        checks++; if (s_out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", s_out_data); end
        checks++; if (s_out_chan !== 2'd0) begin errors++; $display("FAIL rst_out_chan: got %0d want 0", s_out_chan); end
        checks++; if (s_xfer_cnt !== 16'd0) begin errors++; $display("FAIL rst_xfer_cnt: got %0d want 0", s_xfer_cnt); end
        checks++; if (s_sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err: got %b want 0", s_sel_err); end
        checks++; if (s_in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", s_in_ready); end
        rst_n      = 1'b1;
        s_in_valid = 4'b0000;
        #1;
    endtask

    task automatic test_select();
        s_sel       = 2'd2;
        s_in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        s_in_valid  = 4'b0100;
        s_out_ready = 1'b1;
        #1;
        checks++; if (s_in_ready !== 4'b0100) begin errors++; $display("FAIL sel_in_ready: got %b want 0100", s_in_ready); end
        tick();
        s_in_valid = 4'b0000;
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sel_out_valid: got %b want 1", s_out_valid); end
        checks++; if (s_out_data !== 8'hA5) begin errors++; $display("FAIL sel_out_data: got %h want a5", s_out_data); end
        checks++; if (s_out_chan !== 2'd2) begin errors++; $display("FAIL sel_out_chan: got %0d want 2", s_out_chan); end
        checks++; if (s_xfer_cnt !== 16'd0) begin errors++; $display("FAIL sel_xfer_pre: got %0d want 0", s_xfer_cnt); end
        tick();
        checks++; if (s_xfer_cnt !== 16'd1) begin errors++; $display("FAIL sel_xfer_post: got %0d want 1", s_xfer_cnt); end
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain: got %b want 0", s_out_valid); end
    endtask

    task automatic test_back_to_back();
        s_sel            = 2'd1;
        s_out_ready      = 1'b0;
        s_in_data[15:8]  = 8'h11;
        s_in_valid       = 4'b0010;
        tick();
        s_in_data[15:8] = 8'h22;
        for (int k = 0; k < 3; k++) begin
            checks++; if (s_in_ready !== 4'b0000) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0000", k, s_in_ready); end
            checks++; if (s_out_data !== 8'h11 || s_out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/11", k, s_out_valid, s_out_data); end
            tick();
        end
        s_out_ready = 1'b1;
        #1;
        checks++; if (s_in_ready !== 4'b0010) begin errors++; $display("FAIL release_in_ready: got %b want 0010", s_in_ready); end
        tick();
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h22) begin errors++; $display("FAIL b2b_word22: got %b/%h want 1/22", s_out_valid, s_out_data); end
        s_in_data[15:8] = 8'h33;
        tick();
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h33) begin errors++; $display("FAIL b2b_word33: got %b/%h want 1/33", s_out_valid, s_out_data); end
        s_in_valid = 4'b0000;
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", s_out_valid); end
        checks++; if (s_xfer_cnt !== 16'd4) begin errors++; $display("FAIL b2b_xfer_cnt: got %0d want 4", s_xfer_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        s_sel       = 2'd1;
        s_out_ready = 1'b1;
        s_in_valid  = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            s_in_data[15:8] = 8'h40 + 8'(k);
            tick();
        end
        s_out_ready = 1'b0;
        s_in_valid  = 4'b0000;
        tick();
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h43) begin errors++; $display("FAIL pre_rst_hold: got %b/%h want 1/43", s_out_valid, s_out_data); end
        checks++; if (s_xfer_cnt !== 16'd7) begin errors++; $display("FAIL pre_rst_xfer: got %0d want 7", s_xfer_cnt); end
        s_in_valid = 4'b0010;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", s_out_valid); end
        checks++; if (s_xfer_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_xfer: got %0d want 0", s_xfer_cnt); end
        checks++; if (s_out_data !== 8'h00) begin errors++; $display("FAIL async_rst_data: got %h want 00", s_out_data); end
        checks++; if (s_in_ready !== 4'b0000) begin errors++; $display("FAIL async_rst_ready: got %b want 0000", s_in_ready); end
        tick();
        s_in_valid = 4'b0000;
        rst_n      = 1'b1;
        #1;
    endtask

    task automatic test_round_robin();
        int         exp_ch[8];
        logic [7:0] tab[4];
        exp_ch = '{0, 1, 2, 3, 0, 1, 3, 1};
        tab    = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        r_in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        r_out_ready = 1'b1;
        r_in_valid  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) r_in_valid = 4'b1010;
            tick();
            checks++; if (r_out_valid !== 1'b1 || r_out_chan !== 2'(exp_ch[k])) begin errors++; $display("FAIL rr_chan[%0d]: got %b/%0d want 1/%0d", k, r_out_valid, r_out_chan, exp_ch[k]); end
            checks++; if (r_out_data !== tab[exp_ch[k]]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, r_out_data, tab[exp_ch[k]]); end
        end
        r_in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_bad_sel();
        w_in_data   = {8'h3C, 8'h2B, 8'h1A, 8'h09};
        w_sel       = 4'd3;
        w_in_valid  = 4'b1000;
        w_out_ready = 1'b1;
        #1;
        checks++; if (w_in_ready !== 4'b1000) begin errors++; $display("FAIL wide_top_ready: got %b want 1000", w_in_ready); end
        tick();
        checks++; if (w_out_data !== 8'h3C || w_out_chan !== 4'd3) begin errors++; $display("FAIL wide_top_load: got %h/%0d want 3c/3", w_out_data, w_out_chan); end
        checks++; if (w_sel_err !== 1'b0) begin errors++; $display("FAIL wide_top_sel_err: got %b want 0", w_sel_err); end
        w_sel      = 4'd5;
        w_in_valid = 4'b1111;
        #1;
        checks++; if (w_in_ready !== 4'b0000) begin errors++; $display("FAIL bad_sel_ready: got %b want 0000", w_in_ready); end
        tick();
        checks++; if (w_sel_err !== 1'b1) begin errors++; $display("FAIL bad_sel_err: got %b want 1", w_sel_err); end
        checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL bad_sel_no_load: got %b want 0", w_out_valid); end
        w_sel      = 4'd0;
        w_in_valid = 4'b0000;
        repeat (10) tick();
        checks++; if (w_sel_err !== 1'b1) begin errors++; $display("FAIL bad_sel_sticky: got %b want 1", w_sel_err); end
    endtask

    task automatic test_xmerge();
        logic probe;
        probe = 1'bx;
        if (!$isunknown(probe)) begin
            $display("note: two-state simulator, unknown-select row skipped");
            return;
        end
        s_in_data   = {8'h00, 8'h00, 8'hF3, 8'hF0};
        s_in_valid  = 4'b0011;
        s_out_ready = 1'b1;
        s_sel       = 2'b0x;
        #1;
`ifdef MUX_NWAY_XMERGE_EN
        checks++; if (s_in_ready !== 4'b0011) begin errors++; $display("FAIL xm_ready: got %b want 0011", s_in_ready); end
        tick();
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'b1111_00xx) begin errors++; $display("FAIL xm_data: got %b/%b want 1/111100xx", s_out_valid, s_out_data); end
        checks++; if (s_out_chan !== 2'bxx) begin errors++; $display("FAIL xm_chan: got %b want xx", s_out_chan); end
        checks++; if (s_sel_err !== 1'b0) begin errors++; $display("FAIL xm_sel_err: got %b want 0", s_sel_err); end
`else
        checks++; if (s_in_ready !== 4'b0000) begin errors++; $display("FAIL xsel_ready: got %b want 0000", s_in_ready); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL xsel_no_load: got %b want 0", s_out_valid); end
        checks++; if (s_sel_err !== 1'b1) begin errors++; $display("FAIL xsel_sel_err: got %b want 1", s_sel_err); end
`endif
        s_sel      = 2'd0;
        s_in_valid = 4'b0000;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        s_in_valid  = 4'b1111; s_in_data = '0; s_sel = 2'd0; s_out_ready = 1'b0;
        r_in_valid  = 4'b0000; r_in_data = '0; r_sel = 2'd0; r_out_ready = 1'b0;
        w_in_valid  = 4'b0000; w_in_data = '0; w_sel = 4'd0; w_out_ready = 1'b0;
        repeat (2) tick();
        test_reset();
        test_select();
        test_back_to_back();
        test_reset_mid_stall();
        test_round_robin();
        test_bad_sel();
        test_xmerge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
